// File: rtl/fw_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fw_seq_pkg
//  Purpose  : Shared types, constants and helpers for the feature/weight
//             enable-select sequencer.
//  Contents : state_t          - sequencer FSM states
//             DEFAULT_SCHED_25 - power-on schedule for the 25-step round
//             calc_cnt_w()     - index width for a count, minimum 1 bit
//  Revision : 1.0 - initial release
// ============================================================================
package fw_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit i is the select value at step i.
    localparam logic [24:0] DEFAULT_SCHED_25 = 25'h1F5ABF0;

    // Width needed to index n items; never less than one bit so that a
    // single-item index still has a legal port width.
    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fw_sched_bank.sv
`default_nettype none
// ============================================================================
//  Module   : fw_sched_bank
//  Purpose  : NUM_CH x NUM_STEPS schedule register file. One write port,
//             one combinational per-channel bit read at a shared index.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             wr_en/wr_ch/wr_data - schedule write (out-of-range ch dropped)
//             rd_idx              - step index to read
//             rd_bits             - one select bit per channel
//  Revision : 1.0 - initial release
// ============================================================================
module fw_sched_bank
    import fw_seq_pkg::*;
#(
    parameter int                   NUM_STEPS     = 25,
    parameter int                   CNT_W         = 5,
    parameter int                   NUM_CH        = 1,
    parameter logic [NUM_STEPS-1:0] DEFAULT_SCHED = DEFAULT_SCHED_25
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [calc_cnt_w(NUM_CH)-1:0]   wr_ch,
    input  logic [NUM_STEPS-1:0]            wr_data,
    input  logic [CNT_W-1:0]                rd_idx,
    output logic [NUM_CH-1:0]               rd_bits
);

    localparam int CH_W = calc_cnt_w(NUM_CH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NUM_STEPS-1:0] r_sched;
        logic                 w_hit;
        logic [NUM_STEPS-1:0] w_src;

        // Only channel indices that exist can match, so an out-of-range
        // wr_ch simply hits nothing.
        assign w_hit = wr_en && (wr_ch == CH_W'(c));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sched <= DEFAULT_SCHED;
            end else if (w_hit) begin
                r_sched <= wr_data;
            end
        end

        // Forward a write in flight so a run started in the same cycle
        // sees the new word on its very first step.
        assign w_src      = w_hit ? wr_data : r_sched;
        assign rd_bits[c] = w_src[rd_idx];
    end

endmodule
`default_nettype wire

// File: rtl/feature_weight_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : feature_weight_sel_sequencer
//  Purpose  : Steps a counter 0..NUM_STEPS-1 for num_rounds rounds and drives
//             a per-channel feature/weight enable-select from a loadable
//             schedule, with start/busy/done handshake and hold stall.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             start, num_rounds     - launch a run (IDLE only); 0 rounds = 1
//             hold                  - freeze counter/outputs while running
//             sched_we/ch/wdata     - schedule write, accepted in IDLE only
//             busy, done            - running flag, one-cycle end pulse
//             step_valid, cnt,round - current step position
//             feature_weight_en_sel - per-channel select for current step
//  Revision : 1.0 - initial release
// ============================================================================
module feature_weight_sel_sequencer
    import fw_seq_pkg::*;
#(
    parameter int                   NUM_STEPS     = 25,
    parameter int                   CNT_W         = 5,
    parameter int                   NUM_CH        = 1,
    parameter int                   ROUND_W       = 4,
    parameter logic [NUM_STEPS-1:0] DEFAULT_SCHED = DEFAULT_SCHED_25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ROUND_W-1:0]            num_rounds,
    input  logic                          hold,
    input  logic                          sched_we,
    input  logic [calc_cnt_w(NUM_CH)-1:0] sched_ch,
    input  logic [NUM_STEPS-1:0]          sched_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          step_valid,
    output logic [CNT_W-1:0]              cnt,
    output logic [ROUND_W-1:0]            round,
    output logic [NUM_CH-1:0]             feature_weight_en_sel
);

    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(NUM_STEPS - 1);

    state_t               r_state,  w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [ROUND_W-1:0]   r_round,  w_round_nxt;
    logic [ROUND_W-1:0]   r_limit,  w_limit_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic                 r_valid,  w_valid_nxt;
    logic                 r_done,   w_done_nxt;
    logic [NUM_CH-1:0]    r_en_sel, w_en_sel_nxt;

    logic                 w_sched_we;
    logic [CNT_W-1:0]     w_rd_idx;
    logic [NUM_CH-1:0]    w_rd_bits;

    // The schedule is frozen for the whole run.
    assign w_sched_we = sched_we && (r_state == IDLE);

    // Index of the step that will be shown next cycle whenever the select
    // is reloaded: the following step inside a round, otherwise step 0.
    assign w_rd_idx = ((r_state == RUN) && (r_cnt != C_LAST_STEP)) ?
                      r_cnt + CNT_W'(1) : '0;

    fw_sched_bank #(
        .NUM_STEPS     (NUM_STEPS),
        .CNT_W         (CNT_W),
        .NUM_CH        (NUM_CH),
        .DEFAULT_SCHED (DEFAULT_SCHED)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_sched_we),
        .wr_ch   (sched_ch),
        .wr_data (sched_wdata),
        .rd_idx  (w_rd_idx),
        .rd_bits (w_rd_bits)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_round  <= '0;
            r_limit  <= ROUND_W'(1);
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_en_sel <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_round  <= w_round_nxt;
            r_limit  <= w_limit_nxt;
            r_busy   <= w_busy_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
            r_en_sel <= w_en_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_round_nxt  = r_round;
        w_limit_nxt  = r_limit;
        w_busy_nxt   = r_busy;
        w_valid_nxt  = r_valid;
        w_done_nxt   = 1'b0;
        w_en_sel_nxt = r_en_sel;

        case (r_state)
            IDLE: begin
                w_busy_nxt   = 1'b0;
                w_valid_nxt  = 1'b0;
                w_cnt_nxt    = '0;
                w_round_nxt  = '0;
                w_en_sel_nxt = '0;
                if (start) begin
                    w_state_nxt  = RUN;
                    w_busy_nxt   = 1'b1;
                    w_valid_nxt  = 1'b1;
                    w_limit_nxt  = (num_rounds == '0) ? ROUND_W'(1) : num_rounds;
                    w_en_sel_nxt = w_rd_bits;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (r_cnt != C_LAST_STEP) begin
                        w_cnt_nxt    = r_cnt + CNT_W'(1);
                        w_en_sel_nxt = w_rd_bits;
                    end else if (r_round != r_limit - ROUND_W'(1)) begin
                        // Seamless wrap into the next round.
                        w_cnt_nxt    = '0;
                        w_round_nxt  = r_round + ROUND_W'(1);
                        w_en_sel_nxt = w_rd_bits;
                    end else begin
                        w_state_nxt  = IDLE;
                        w_busy_nxt   = 1'b0;
                        w_valid_nxt  = 1'b0;
                        w_cnt_nxt    = '0;
                        w_round_nxt  = '0;
                        w_en_sel_nxt = '0;
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy                  = r_busy;
    assign done                  = r_done;
    assign step_valid            = r_valid;
    assign cnt                   = r_cnt;
    assign round                 = r_round;
    assign feature_weight_en_sel = r_en_sel;

endmodule
`default_nettype wire

// File: tb/tb_feature_weight_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_feature_weight_sel_sequencer
//  Purpose  : Self-checking bench for feature_weight_sel_sequencer (2 ch).
//             A run-level model (step position, total steps, schedule words)
//             predicts every output each cycle; directed scenarios add
//             hand-computed checks on patterns, latencies and pulse counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_feature_weight_sel_sequencer;

    localparam int          NS  = 25;
    localparam int          NCH = 2;
    localparam int          RW  = 4;
    localparam int          CW  = 5;
    localparam logic [24:0] DEF = 25'h1F5ABF0;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [RW-1:0]   num_rounds = '0;
    logic            hold = 1'b0;
    logic            sched_we = 1'b0;
    logic [0:0]      sched_ch = '0;
    logic [NS-1:0]   sched_wdata = '0;
    logic            busy, done, step_valid;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   round;
    logic [NCH-1:0]  en_sel;

    feature_weight_sel_sequencer #(
        .NUM_STEPS (NS),
        .CNT_W     (CW),
        .NUM_CH    (NCH),
        .ROUND_W   (RW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .num_rounds            (num_rounds),
        .hold                  (hold),
        .sched_we              (sched_we),
        .sched_ch              (sched_ch),
        .sched_wdata           (sched_wdata),
        .busy                  (busy),
        .done                  (done),
        .step_valid            (step_valid),
        .cnt                   (cnt),
        .round                 (round),
        .feature_weight_en_sel (en_sel)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is just "position m_pos out of m_total steps"; cnt and round
    // follow from division by the round length.
    bit          m_run  = 1'b0;
    bit          m_done = 1'b0;
    int          m_pos  = 0;
    int          m_total = 0;
    logic [24:0] m_sched [NCH] = '{DEF, DEF};

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_run = 1'b0; m_done = 1'b0; m_pos = 0;
            m_sched[0] = DEF; m_sched[1] = DEF;
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (sched_we) m_sched[sched_ch] = sched_wdata;
                if (start) begin
                    m_run   = 1'b1;
                    m_pos   = 0;
                    m_total = NS * ((num_rounds == 0) ? 1 : int'(num_rounds));
                end
            end else if (!hold) begin
                m_pos++;
                if (m_pos == m_total) begin
                    m_run = 1'b0; m_done = 1'b1; m_pos = 0;
                end
            end
        end
    end

    // ---------------- compare + monitors ----------------
    int          mon_busy = 0, mon_done = 0, mon_c7 = 0, max_round = 0;
    int          done_cyc = 0, start_cyc = 0;
    logic [24:0] pat0 = '0, pat1 = '0;

    always @(negedge clk) begin : cmp
        int         ec, er;
        logic [1:0] ee;
        if (chk_en) begin
            ec = m_run ? m_pos % NS : 0;
            er = m_run ? m_pos / NS : 0;
            ee = m_run ? {m_sched[1][ec], m_sched[0][ec]} : 2'b00;
            chk("busy",       32'(busy),       32'(m_run));
            chk("step_valid", 32'(step_valid), 32'(m_run));
            chk("done",       32'(done),       32'(m_done));
            chk("cnt",        32'(cnt),        32'(ec));
            chk("round",      32'(round),      32'(er));
            chk("en_sel",     32'(en_sel),     32'(ee));
            if (busy) mon_busy++;
            if (done) begin mon_done++; done_cyc = cyc; end
            if (step_valid) begin
                pat0[cnt] = en_sel[0];
                pat1[cnt] = en_sel[1];
                if (int'(round) > max_round) max_round = int'(round);
                if (cnt == 5'd7) mon_c7++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_busy = 0; mon_done = 0; mon_c7 = 0; max_round = 0;
        pat0 = '0; pat1 = '0;
    endtask

    task automatic start_run(input logic [RW-1:0] nr);
        clear_mon();
        start      = 1'b1;
        num_rounds = nr;
        start_cyc  = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (mon_done == 0 && n < 400) begin
            tick();
            n++;
        end
        if (mon_done == 0) chk("done_timeout", 32'(mon_done), 32'd1);
    endtask

    task automatic wait_cnt(input logic [CW-1:0] target);
        int n = 0;
        while (!(step_valid && cnt == target) && n < 100) begin
            tick();
            n++;
        end
        chk("wait_cnt", 32'(cnt), 32'(target));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick(); tick(); tick();
        chk_en = 1'b1;
        tick();
        chk("rst_busy", 32'(busy),   32'd0);
        chk("rst_cnt",  32'(cnt),    32'd0);
        chk("rst_en",   32'(en_sel), 32'd0);
        reset = 1'b0;
        tick(); tick();

        // Single round, default schedule on both channels.
        start_run(4'd1);
        wait_done();
        chk("t1_pat0",     32'(pat0), 32'(DEF));
        chk("t1_pat1",     32'(pat1), 32'(DEF));
        chk("t1_busy",     32'(mon_busy), 32'd25);
        chk("t1_done_lat", 32'(done_cyc - start_cyc), 32'd26);
        tick();
        chk("t1_done_cnt", 32'(mon_done), 32'd1);

        // Three rounds back to back.
        tick();
        start_run(4'd3);
        wait_done();
        chk("t2_busy",     32'(mon_busy),  32'd75);
        chk("t2_maxround", 32'(max_round), 32'd2);
        chk("t2_done_lat", 32'(done_cyc - start_cyc), 32'd76);
        tick();
        chk("t2_done_cnt", 32'(mon_done), 32'd1);

        // Hold for three cycles at cnt=7.
        tick();
        start_run(4'd1);
        wait_cnt(5'd7);
        hold = 1'b1;
        tick(); tick(); tick();
        hold = 1'b0;
        wait_done();
        chk("t3_cnt7_cycles", 32'(mon_c7),   32'd4);
        chk("t3_busy",        32'(mon_busy), 32'd28);
        chk("t3_done_lat",    32'(done_cyc - start_cyc), 32'd29);

        // Write ch1 in IDLE, then run; a mid-run write to ch0 is dropped.
        tick();
        sched_we = 1'b1; sched_ch = 1'b1; sched_wdata = 25'h0000001;
        tick();
        sched_we = 1'b0;
        start_run(4'd1);
        tick(); tick(); tick();
        sched_we = 1'b1; sched_ch = 1'b0; sched_wdata = 25'h0000000;
        tick();
        sched_we = 1'b0;
        wait_done();
        chk("t4_pat0", 32'(pat0), 32'(DEF));
        chk("t4_pat1", 32'(pat1), 32'h0000001);

        // Write and start in the same cycle: run uses the new word.
        tick();
        sched_we = 1'b1; sched_ch = 1'b1; sched_wdata = 25'h1555555;
        start_run(4'd1);
        sched_we = 1'b0;
        wait_done();
        chk("t5_pat0", 32'(pat0), 32'(DEF));
        chk("t5_pat1", 32'(pat1), 32'h1555555);

        // Reset mid-run at cnt=12.
        tick();
        start_run(4'd1);
        wait_cnt(5'd12);
        reset = 1'b1;
        tick();
        chk("t6_busy",  32'(busy),       32'd0);
        chk("t6_valid", 32'(step_valid), 32'd0);
        chk("t6_cnt",   32'(cnt),        32'd0);
        chk("t6_round", 32'(round),      32'd0);
        chk("t6_en",    32'(en_sel),     32'd0);
        reset = 1'b0;
        clear_mon();
        tick(); tick(); tick();
        chk("t6_no_done", 32'(mon_done), 32'd0);
        start_run(4'd1);
        wait_done();
        chk("t6_pat1_restored", 32'(pat1), 32'(DEF));

        // num_rounds=0 runs one round; a start during RUN is ignored.
        tick();
        start_run(4'd0);
        tick(); tick(); tick(); tick(); tick();
        start = 1'b1; num_rounds = 4'd5;
        tick();
        start = 1'b0;
        wait_done();
        chk("t7_busy",     32'(mon_busy), 32'd25);
        chk("t7_done_lat", 32'(done_cyc - start_cyc), 32'd26);

        // Start raised in the done cycle is accepted.
        start_run(4'd1);
        wait_done();
        chk("t8_busy",     32'(mon_busy), 32'd25);
        chk("t8_done_lat", 32'(done_cyc - start_cyc), 32'd26);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/feature_weight_sel_sequencer.md
Name: feature_weight_sel_sequencer

Overview:
Parametrised successor to the fixed 5-bit count-to-enable-select decoder used by the feature/weight buffer path. It owns its own step counter and drives a per-channel feature/weight enable-select from a run-time-loadable schedule, not hard-wired logic. It runs a start/busy/done handshake with the PE-array controller and supports stalls and multi-round repetition. It sits between the top controller FSM and the feature/weight buffer muxes.

Parameters:
NUM_STEPS, 25, steps per round; counter runs 0..NUM_STEPS-1
CNT_W, 5, counter width; must satisfy 2**CNT_W >= NUM_STEPS
NUM_CH, 1, independent select channels, each with its own schedule
ROUND_W, 4, width of the round-count input
DEFAULT_SCHED, 25'h1F5ABF0, reset schedule loaded into every channel; bit i is the select value at step i

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
num_rounds  in  ROUND_W  rounds to execute, sampled with start; 0 is treated as 1
hold  in  1  stall; freezes counter and outputs while RUN
sched_we  in  1  schedule write strobe
sched_ch  in  max(1,$clog2(NUM_CH))  channel written
sched_wdata  in  NUM_STEPS  new schedule word
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last step of the last round
step_valid  out  1  cnt/en_sel are meaningful this cycle
cnt  out  CNT_W  current step index
round  out  ROUND_W  current round index, starting at 0
feature_weight_en_sel  out  NUM_CH  per-channel select for the current step

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-run): state=IDLE; busy=0, done=0, step_valid=0, cnt=0, round=0, feature_weight_en_sel=0; every channel's schedule = DEFAULT_SCHED.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE: outputs as at reset, except the schedules keep their contents.
- IDLE + start at cycle T: at T+1 state=RUN, busy=1, step_valid=1, cnt=0, round=0, en_sel[c]=sched[c][0]. The round limit is latched from num_rounds at T.
- RUN, hold=0: advance one step per cycle. en_sel[c] always equals sched[c][cnt] in the same cycle.
- RUN, hold=1: cnt, round, en_sel and step_valid stay unchanged. busy stays 1.
- End of round, with cnt==NUM_STEPS-1 and hold=0:
  - if round < limit-1: cnt wraps to 0 and round increments, with no bubble cycle.
  - else: next cycle state=IDLE, busy=0, step_valid=0, cnt=0, en_sel=0, done=1 for exactly one cycle.
- start while RUN: ignored. start in the same cycle done is high: accepted, because state is already IDLE.
- A run of NUM_STEPS=25 with 1 round and no holds therefore takes 25 busy cycles, with done on the 26th cycle after start.
- Schedule writes:
  - Accepted only in IDLE; sched_we during RUN is dropped, so the schedule stays stable for the whole run.
  - A write takes effect the cycle after sched_we.
  - start and sched_we in the same IDLE cycle: the write lands first, and the run uses the new schedule.
  - An out-of-range sched_ch (>= NUM_CH) is dropped.
- Counter arithmetic is unsigned and CNT_W wide. Compare against NUM_STEPS-1 only, never on overflow.

Decomposition:
- Shared package fw_seq_pkg holds:
  - state enum {IDLE, RUN};
  - DEFAULT_SCHED_25 constant 25'h1F5ABF0;
  - CNT_W helper function.
- One sub-module, fw_sched_bank: NUM_CH x NUM_STEPS schedule register file with write port and a combinational per-channel read indexed by cnt.
- Top level holds the FSM, counter and round logic.

Test Plan:
- Reset, then start with num_rounds=1 and hold=0 -> en_sel over cnt 0..24 reads 0000 1111 1101 0101 1010 1111 1; busy is high 25 cycles; done pulses once on cycle 26.
- Start with num_rounds=3 -> cnt wraps 24->0 with no gap; round goes 0,1,2; 75 busy cycles; a single done pulse.
- Hold=1 for 3 cycles at cnt=7 -> cnt=7 and en_sel=1 are held 4 cycles total; done arrives 3 cycles later than the baseline run.
- NUM_CH=2: in IDLE write ch1 = 25'h0000001, then start -> ch0 follows the default pattern; ch1 is 1 only at cnt=0. A sched_we issued mid-run has no effect, confirmed on the next run.
- Assert reset at cnt=12 of a run -> the next cycle shows all outputs 0, state IDLE and the schedule restored to the default; no done pulse.
- Start pulsed during RUN, and num_rounds=0 -> the extra start is ignored; num_rounds=0 runs exactly 1 round.
